stopwatch_button_ctrl: RTL and testbench

//  Front-end control stage for the stopwatch timer. It takes two raw, bouncing push-buttons:
//  - btn_ss: start/stop toggle.
//  - btn_lr: lap / long-press clear.
//  It synchronises and debounces both, runs a run/pause FSM and emits single-cycle

---
 rtl/stopwatch_button_ctrl_if.sv | 18 +
 rtl/stopwatch_button_ctrl.sv | 86 ++++++++
 tb/tb_stopwatch_button_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_button_ctrl_if.sv
// stopwatch_button_ctrl_if: raw button inputs and registered control pulses of the stopwatch front end
interface stopwatch_button_ctrl_if;
  logic i_btn_ss;
  logic i_btn_lr;
  logic o_start;
  logic o_stop;
  logic o_lap;
  logic o_clear;
  logic o_running;
  modport master (
    output i_btn_ss, i_btn_lr,
    input  o_start, o_stop, o_lap, o_clear, o_running
  );
  modport slave (
    input  i_btn_ss, i_btn_lr,
    output o_start, o_stop, o_lap, o_clear, o_running
  );
endinterface

// File: rtl/stopwatch_button_ctrl.sv
// stopwatch_button_ctrl: sync/debounce two buttons, run/pause FSM, start/stop/lap/long-press clear pulses
module stopwatch_button_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  stopwatch_button_ctrl_if.slave  bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;
  logic [1:0]    w_raw;
  logic [1:0]    w_stb;
  logic [1:0]    w_press;
  logic [HW-1:0] r_hcnt;
  logic          w_clr_evt;
  state_t        r_state;
  state_t        w_state_n;
  logic          r_start, r_stop, r_lap, r_clear, r_running;
  logic          w_start_n, w_stop_n, w_lap_n, w_clear_n;
  assign w_raw = {bus.i_btn_lr, bus.i_btn_ss};
  for (genvar d = 0; d < 2; d++) begin : g_db
    logic          r_s1, r_s2, r_stb;
    logic [DW-1:0] r_cnt;
    logic          w_flip;
    // the press event is the edge on which stable is about to rise, so it lines up with that update
    assign w_flip     = (r_s2 != r_stb) && (r_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign w_press[d] = w_flip & r_s2;
    assign w_stb[d]   = r_stb;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1  <= 1'b0;
        r_s2  <= 1'b0;
        r_stb <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_s1  <= w_raw[d];
        r_s2  <= r_s1;
        r_cnt <= (r_s2 == r_stb || w_flip) ? '0 : r_cnt + DW'(1);
        if (w_flip) r_stb <= r_s2;
      end
    end
  end
  assign w_clr_evt = w_stb[1] && (r_hcnt == HW'(LONG_PRESS_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset) r_hcnt <= '0;
    else if (w_press[1]) r_hcnt <= '0;
    else if (w_stb[1] && r_hcnt != HW'(LONG_PRESS_CYCLES)) r_hcnt <= r_hcnt + HW'(1);
  end
  always_comb begin
    w_state_n = r_state;
    w_start_n = 1'b0;
    w_stop_n  = 1'b0;
    w_lap_n   = w_press[1] && (r_state == RUNNING);
    w_clear_n = w_clr_evt;
    if (w_clr_evt) w_state_n = IDLE;
    else if (w_press[0]) begin
      w_start_n = (r_state != RUNNING);
      w_stop_n  = (r_state == RUNNING);
      w_state_n = (r_state == RUNNING) ? PAUSED : RUNNING;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_lap     <= 1'b0;
      r_clear   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_start   <= w_start_n;
      r_stop    <= w_stop_n;
      r_lap     <= w_lap_n;
      r_clear   <= w_clear_n;
      r_running <= (w_state_n == RUNNING);
    end
  end
  assign bus.o_start   = r_start;
  assign bus.o_stop    = r_stop;
  assign bus.o_lap     = r_lap;
  assign bus.o_clear   = r_clear;
  assign bus.o_running = r_running;
endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// tb_stopwatch_button_ctrl: directed button scenarios checked against a window/event-level model every cycle
module tb_stopwatch_button_ctrl;
  localparam int DEB  = 4;
  localparam int LONG = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  stopwatch_button_ctrl_if bus ();
  stopwatch_button_ctrl #(.DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef enum {M_IDLE, M_RUN, M_PAUSE} mst_t;
  bit   hist [2][0:DEB];
  bit   m_stb [2];
  int   cyc = 0;
  int   lr_p = 0;
  bit   lr_v = 0;
  mst_t m_st = M_IDLE;
  bit   e_start, e_stop, e_lap, e_clear, e_run;
  task automatic chk(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", n, a, e, $time);
    end
  endtask
  // a level is accepted once the synchronised samples of the last DEB edges all differ from it
  always @(posedge clk) begin
    bit raw [2];
    bit press [2];
    bit flip;
    bit clr;
    cyc++;
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        m_stb[b] = 0;
        for (int j = 0; j <= DEB; j++) hist[b][j] = 0;
      end
      lr_v = 0;
      m_st = M_IDLE;
      {e_start, e_stop, e_lap, e_clear, e_run} = '0;
    end else begin
      raw[0] = bus.i_btn_ss;
      raw[1] = bus.i_btn_lr;
      clr = lr_v && (cyc - lr_p == LONG);
      for (int b = 0; b < 2; b++) begin
        flip = 1;
        for (int j = 1; j <= DEB; j++) if (hist[b][j] == m_stb[b]) flip = 0;
        press[b] = flip && !m_stb[b];
        if (flip) m_stb[b] = !m_stb[b];
        for (int j = DEB; j >= 1; j--) hist[b][j] = hist[b][j-1];
        hist[b][0] = raw[b];
      end
      if (press[1]) begin
        lr_p = cyc;
        lr_v = 1;
      end else if (!m_stb[1]) lr_v = 0;
      e_lap   = press[1] && m_st == M_RUN;
      e_clear = clr;
      e_start = 0;
      e_stop  = 0;
      if (clr) m_st = M_IDLE;
      else if (press[0]) begin
        e_start = m_st != M_RUN;
        e_stop  = m_st == M_RUN;
        m_st    = (m_st == M_RUN) ? M_PAUSE : M_RUN;
      end
      e_run = m_st == M_RUN;
    end
  end
  always @(negedge clk) begin
    chk("m_start", bus.o_start, e_start);
    chk("m_stop", bus.o_stop, e_stop);
    chk("m_lap", bus.o_lap, e_lap);
    chk("m_clear", bus.o_clear, e_clear);
    chk("m_running", bus.o_running, e_run);
    chk("start_stop_excl", bus.o_start & bus.o_stop, 1'b0);
  end
  task automatic wn(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic ss_press(input bit want_start);
    bus.i_btn_ss = 1;
    wn(6);
    chk(want_start ? "lit_start" : "lit_stop", want_start ? bus.o_start : bus.o_stop, 1'b1);
    chk("lit_run_after_ss", bus.o_running, want_start);
    wn(4);
    bus.i_btn_ss = 0;
    wn(8);
  endtask
  initial begin
    bus.i_btn_ss = 0;
    bus.i_btn_lr = 0;
    wn(3);
    chk("rst_start", bus.o_start, 1'b0);
    chk("rst_running", bus.o_running, 1'b0);
    chk("rst_clear", bus.o_clear, 1'b0);
    reset = 0;
    wn(2);
    bus.i_btn_ss = 1;
    wn(5);
    chk("t1_start_early", bus.o_start, 1'b0);
    wn(1);
    chk("t1_start", bus.o_start, 1'b1);
    chk("t1_running", bus.o_running, 1'b1);
    wn(1);
    chk("t1_start_1cyc", bus.o_start, 1'b0);
    wn(3);
    bus.i_btn_ss = 0;
    wn(8);
    bus.i_btn_ss = 1; wn(1);
    bus.i_btn_ss = 0; wn(1);
    bus.i_btn_ss = 1; wn(1);
    bus.i_btn_ss = 0; wn(1);
    bus.i_btn_ss = 1;
    wn(5);
    chk("t2_stop_early", bus.o_stop, 1'b0);
    wn(1);
    chk("t2_stop", bus.o_stop, 1'b1);
    chk("t2_running", bus.o_running, 1'b0);
    wn(4);
    bus.i_btn_ss = 0;
    wn(8);
    ss_press(1);
    bus.i_btn_lr = 1;
    wn(6);
    chk("t4_lap", bus.o_lap, 1'b1);
    wn(5);
    bus.i_btn_lr = 0;
    wn(20);
    chk("t4_still_running", bus.o_running, 1'b1);
    chk("t4_no_clear", bus.o_clear, 1'b0);
    ss_press(0);
    bus.i_btn_lr = 1;
    wn(6);
    chk("t5_no_lap", bus.o_lap, 1'b0);
    wn(15);
    chk("t5_clear_early", bus.o_clear, 1'b0);
    wn(1);
    chk("t5_clear", bus.o_clear, 1'b1);
    chk("t5_running", bus.o_running, 1'b0);
    wn(1);
    chk("t5_clear_once", bus.o_clear, 1'b0);
    wn(17);
    bus.i_btn_lr = 0;
    wn(8);
    ss_press(1);
    bus.i_btn_lr = 1;
    wn(16);
    bus.i_btn_ss = 1;
    wn(6);
    chk("t6_clear", bus.o_clear, 1'b1);
    chk("t6_no_stop", bus.o_stop, 1'b0);
    chk("t6_no_start", bus.o_start, 1'b0);
    chk("t6_idle", bus.o_running, 1'b0);
    wn(4);
    bus.i_btn_lr = 0;
    bus.i_btn_ss = 0;
    wn(10);
    bus.i_btn_ss = 1;
    wn(4);
    reset = 1;
    wn(1);
    reset = 0;
    bus.i_btn_ss = 0;
    wn(10);
    chk("t7_no_start", bus.o_start, 1'b0);
    chk("t7_idle", bus.o_running, 1'b0);
    bus.i_btn_ss = 1;
    reset = 1;
    wn(2);
    reset = 0;
    wn(5);
    chk("t8_start_early", bus.o_start, 1'b0);
    wn(1);
    chk("t8_start", bus.o_start, 1'b1);
    wn(3);
    bus.i_btn_ss = 0;
    wn(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
